// File: rtl/spi_requester_arbiter_pkg.sv
// spi_arb_pkg: shared types for the SPI requester arbiter.
//   spi_xfer_cfg_t  - per-transfer controller configuration
//   arb_state_e     - arbiter FSM states
//   Bit_Index_Width - width of the transfer bit-count field
package spi_arb_pkg;

  function automatic int unsigned bit_index_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Data/mask width carried in the configuration struct; the arbiter's
  // Max_Bit_Width parameter is expected to match it.
  localparam int unsigned Cfg_Bit_Width   = 32;
  localparam int unsigned Bit_Index_Width = bit_index_width(Cfg_Bit_Width);
  localparam int unsigned Divisor_Width   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [Divisor_Width-1:0]   divisor;
    logic                       cpol;
    logic                       cpha;
    logic                       start_pol;
    logic [Bit_Index_Width-1:0] width;
    logic [Cfg_Bit_Width-1:0]   copi_data;
    logic [Cfg_Bit_Width-1:0]   copi_mask;
    logic [Cfg_Bit_Width-1:0]   cipo_mask;
  } spi_xfer_cfg_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational rotate-priority grant.
//   req         - request vector
//   last_idx    - index granted last; search starts one above it and wraps
//   grant_c     - one-hot grant
//   grant_idx_c - index of the granted requester
//   grant_any_c - some requester was granted
module spi_rr_arbiter #(
  parameter int unsigned Requester_Count = 4,
  parameter int unsigned Idx_Width       = $clog2(Requester_Count)
) (
  input  logic [Requester_Count-1:0] req,
  input  logic [Idx_Width-1:0]       last_idx,
  output logic [Requester_Count-1:0] grant_c,
  output logic [Idx_Width-1:0]       grant_idx_c,
  output logic                       grant_any_c
);

  // First requester found walking upward from last_idx+1, modulo the count.
  always_comb begin : p_grant
    int unsigned cand;
    logic [Idx_Width-1:0] cand_idx;
    cand        = '0;
    cand_idx    = '0;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    for (int unsigned k = 1; k <= Requester_Count; k++) begin
      cand     = (32'(last_idx) + k) % Requester_Count;
      cand_idx = Idx_Width'(cand);
      if (!grant_any_c && req[cand_idx]) begin
        grant_any_c           = 1'b1;
        grant_idx_c           = cand_idx;
        grant_c[cand_idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_requester_arbiter.sv
// spi_requester_arbiter: shares one SPI controller among Requester_Count
// requesters with round-robin grant and a four-state transfer FSM.
// Optional feature: define SPI_ARB_LOCK_EN to add req_lock, which keeps the
// bus with the current owner across transfers and drives spi_cs_override.
// Ports:
//   clk, async_rst (async, active-high), clk_en (global advance enable)
//   req_valid/req_cfg[/req_lock]        - requester side inputs
//   req_ack/req_nak/rsp_valid           - one-hot, one-cycle pulses to owner
//   rsp_cipo_data                       - captured read data, valid with rsp_valid
//   spi_start_req/spi_cfg/spi_end_ack/spi_cs_override - to controller
//   spi_start_ack/spi_start_nak/spi_end_req/spi_cipo_data - from controller
module spi_requester_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned Requester_Count = 4,
  parameter int unsigned Max_Bit_Width   = 32
) (
  input  logic                                       clk,
  input  logic                                       async_rst,
  input  logic                                       clk_en,
  input  logic          [Requester_Count-1:0]        req_valid,
  input  spi_xfer_cfg_t [Requester_Count-1:0]        req_cfg,
`ifdef SPI_ARB_LOCK_EN
  input  logic          [Requester_Count-1:0]        req_lock,
`endif
  output logic          [Requester_Count-1:0]        req_ack,
  output logic          [Requester_Count-1:0]        req_nak,
  output logic          [Requester_Count-1:0]        rsp_valid,
  output logic          [Max_Bit_Width-1:0]          rsp_cipo_data,
  output logic                                       spi_start_req,
  output spi_xfer_cfg_t                              spi_cfg,
  input  logic                                       spi_start_ack,
  input  logic                                       spi_start_nak,
  input  logic                                       spi_end_req,
  input  logic          [Max_Bit_Width-1:0]          spi_cipo_data,
  output logic                                       spi_end_ack,
  output logic                                       spi_cs_override
);

  localparam int unsigned Idx_Width = $clog2(Requester_Count);

  arb_state_e                 state_q, state_d;
  logic [Requester_Count-1:0] owner_oh_q, owner_oh_d;
  logic [Idx_Width-1:0]       last_q, last_d;
  spi_xfer_cfg_t              cfg_d;
  logic [Max_Bit_Width-1:0]   cipo_d;
  logic [Requester_Count-1:0] req_ack_d, req_nak_d, rsp_valid_d;
  logic                       start_req_d, end_ack_d, cs_override_d;
  logic [Requester_Count-1:0] arb_req_c;
  logic [Requester_Count-1:0] grant_c;
  logic [Idx_Width-1:0]       grant_idx_c;
  logic                       grant_any_c;
`ifdef SPI_ARB_LOCK_EN
  logic                       lock_hold_q, lock_hold_d;
`endif

  // Arbiter request: a held lock narrows the choice to the previous owner.
  always_comb begin
    arb_req_c = req_valid;
`ifdef SPI_ARB_LOCK_EN
    if (lock_hold_q && |(req_valid & owner_oh_q)) begin
      arb_req_c = owner_oh_q;
    end
`endif
  end

  spi_rr_arbiter #(
    .Requester_Count (Requester_Count),
    .Idx_Width       (Idx_Width)
  ) u_rr (
    .req         (arb_req_c),
    .last_idx    (last_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    owner_oh_d    = owner_oh_q;
    last_d        = last_q;
    cfg_d         = spi_cfg;
    cipo_d        = rsp_cipo_data;
    req_ack_d     = '0;
    req_nak_d     = '0;
    rsp_valid_d   = '0;
    start_req_d   = 1'b0;
    end_ack_d     = 1'b0;
    cs_override_d = spi_cs_override;
`ifdef SPI_ARB_LOCK_EN
    lock_hold_d   = lock_hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any_c) begin
          owner_oh_d  = grant_c;
          last_d      = grant_idx_c;
          cfg_d       = req_cfg[grant_idx_c];
          start_req_d = 1'b1;
          state_d     = START;
`ifdef SPI_ARB_LOCK_EN
          if (|(req_lock & grant_c)) begin
            cs_override_d = 1'b1;
          end
`endif
        end
      end
      START: begin
        // Simultaneous ack and nak resolve as nak.
        if (spi_start_nak) begin
          req_nak_d = owner_oh_q;
          state_d   = IDLE;
        end else if (spi_start_ack) begin
          req_ack_d = owner_oh_q;
          state_d   = ACTIVE;
        end else begin
          start_req_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (spi_end_req) begin
          cipo_d      = spi_cipo_data;
          end_ack_d   = 1'b1;
          rsp_valid_d = owner_oh_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef SPI_ARB_LOCK_EN
        lock_hold_d = |(req_lock & owner_oh_q);
        if (!(|(req_lock & owner_oh_q))) begin
          cs_override_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; everything holds while clk_en is low.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q         <= IDLE;
      owner_oh_q      <= '0;
      last_q          <= Idx_Width'(Requester_Count - 1);
      spi_cfg         <= '0;
      rsp_cipo_data   <= '0;
      req_ack         <= '0;
      req_nak         <= '0;
      rsp_valid       <= '0;
      spi_start_req   <= 1'b0;
      spi_end_ack     <= 1'b0;
      spi_cs_override <= 1'b0;
`ifdef SPI_ARB_LOCK_EN
      lock_hold_q     <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q         <= state_d;
      owner_oh_q      <= owner_oh_d;
      last_q          <= last_d;
      spi_cfg         <= cfg_d;
      rsp_cipo_data   <= cipo_d;
      req_ack         <= req_ack_d;
      req_nak         <= req_nak_d;
      rsp_valid       <= rsp_valid_d;
      spi_start_req   <= start_req_d;
      spi_end_ack     <= end_ack_d;
      spi_cs_override <= cs_override_d;
`ifdef SPI_ARB_LOCK_EN
      lock_hold_q     <= lock_hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_requester_arbiter.sv
// Bench for spi_requester_arbiter: directed scenarios plus a randomized
// transfer stream checked against a round-robin reference model.
// The lock scenario is included when SPI_ARB_LOCK_EN is defined.
module tb_spi_requester_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic                    clk = 1'b0;
  logic                    async_rst;
  logic                    clk_en;
  logic [N-1:0]            req_valid;
  spi_xfer_cfg_t [N-1:0]   req_cfg;
`ifdef SPI_ARB_LOCK_EN
  logic [N-1:0]            req_lock;
`endif
  logic [N-1:0]            req_ack, req_nak, rsp_valid;
  logic [W-1:0]            rsp_cipo_data;
  logic                    spi_start_req;
  spi_xfer_cfg_t           spi_cfg;
  logic                    spi_start_ack, spi_start_nak, spi_end_req;
  logic [W-1:0]            spi_cipo_data;
  logic                    spi_end_ack, spi_cs_override;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  spi_xfer_cfg_t cfg_tab [N];
  logic [N-1:0]  pending;
  int            last_grant;
  bit            ok;

  spi_requester_arbiter #(.Requester_Count(N), .Max_Bit_Width(W)) dut (
    .clk             (clk),
    .async_rst       (async_rst),
    .clk_en          (clk_en),
    .req_valid       (req_valid),
    .req_cfg         (req_cfg),
`ifdef SPI_ARB_LOCK_EN
    .req_lock        (req_lock),
`endif
    .req_ack         (req_ack),
    .req_nak         (req_nak),
    .rsp_valid       (rsp_valid),
    .rsp_cipo_data   (rsp_cipo_data),
    .spi_start_req   (spi_start_req),
    .spi_cfg         (spi_cfg),
    .spi_start_ack   (spi_start_ack),
    .spi_start_nak   (spi_start_nak),
    .spi_end_req     (spi_end_req),
    .spi_cipo_data   (spi_cipo_data),
    .spi_end_ack     (spi_end_ack),
    .spi_cs_override (spi_cs_override)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int idx);
    return N'(1) << idx;
  endfunction

  // Round robin from the rules: first pending index above last, wrapping.
  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    async_rst     = 1'b1;
    req_valid     = '0;
    spi_start_ack = 1'b0;
    spi_start_nak = 1'b0;
    spi_end_req   = 1'b0;
    spi_cipo_data = '0;
    pending       = '0;
    last_grant    = N - 1;
    step();
    step();
    async_rst = 1'b0;
  endtask

  // New requesters raise req_valid with a fresh random cfg.
  task automatic raise(input logic [N-1:0] mask);
    logic [127:0] r;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !pending[i]) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        cfg_tab[i]   = r[$bits(spi_xfer_cfg_t)-1:0];
        req_cfg[i]   = cfg_tab[i];
        pending[i]   = 1'b1;
        req_valid[i] = 1'b1;
      end
    end
  endtask

  // Wait for the grant, check cfg/cs, then accept or reject the start.
  task automatic begin_xfer(input int owner, input bit nak, input bit both, input int d_ack,
                            input bit drop_owner, input logic [N-1:0] late, input bit exp_cs,
                            output bit accepted);
    bit seen;
    spi_xfer_cfg_t c;
    accepted = 1'b0;
    c        = cfg_tab[owner];
    seen     = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      step();
      seen = spi_start_req;
    end
    check("start_req_seen", 128'(seen), 128'(1));
    if (!seen) return;
    check("spi_cfg", 128'(spi_cfg), 128'(c));
    check("cs_override", 128'(spi_cs_override), 128'(exp_cs));
    if (drop_owner) req_valid[owner] = 1'b0;
    raise(late);
    for (int n = 0; n < d_ack; n++) begin
      step();
      check("start_req_hold", 128'(spi_start_req), 128'(1));
      check("spi_cfg_stable", 128'(spi_cfg), 128'(c));
    end
    spi_start_ack = !nak || both;
    spi_start_nak = nak;
    step();
    spi_start_ack = 1'b0;
    spi_start_nak = 1'b0;
    check("req_ack", 128'(req_ack), 128'(nak ? '0 : oh(owner)));
    check("req_nak", 128'(req_nak), 128'(nak ? oh(owner) : '0));
    check("start_req_drop", 128'(spi_start_req), 128'(0));
    pending[owner]   = 1'b0;
    req_valid[owner] = 1'b0;
    accepted         = !nak;
  endtask

  task automatic end_xfer(input int owner, input int d_end, input logic [W-1:0] data);
    for (int n = 0; n < d_end; n++) begin
      step();
      check("rsp_early", 128'(rsp_valid), 128'(0));
    end
    spi_end_req   = 1'b1;
    spi_cipo_data = data;
    step();
    spi_end_req   = 1'b0;
    spi_cipo_data = W'($urandom);
    check("end_ack", 128'(spi_end_ack), 128'(1));
    check("rsp_valid", 128'(rsp_valid), 128'(oh(owner)));
    check("rsp_cipo", 128'(rsp_cipo_data), 128'(data));
    step();
    check("end_ack_pulse", 128'(spi_end_ack), 128'(0));
    check("rsp_valid_pulse", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    int owner;
    logic [N-1:0] add;
    bit nak;
    clk_en    = 1'b1;
    req_valid = '0;
    req_cfg   = '0;
`ifdef SPI_ARB_LOCK_EN
    req_lock  = '0;
`endif
    do_reset();
    check("rst_pulses", 128'({req_ack, req_nak, rsp_valid}), 128'(0));
    check("rst_ctrl", 128'({spi_start_req, spi_end_ack, spi_cs_override}), 128'(0));
    check("rst_data", 128'(rsp_cipo_data), 128'(0));
    check("rst_cfg", 128'(spi_cfg), 128'(0));

    // Single request
    raise(4'b0001);
    begin_xfer(0, 1'b0, 1'b0, 1, 1'b0, '0, 1'b0, ok);
    if (ok) end_xfer(0, 2, 32'h00A5_0000);

    // Everyone requesting continuously: strict rotation from 0
    do_reset();
    raise(4'b1111);
    for (int k = 0; k < 5; k++) begin
      begin_xfer(k % 4, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
      if (ok) end_xfer(k % 4, 1, W'($urandom));
      raise(oh(k % 4));
    end

    // Nak (ack and nak together) on requester 2, then requester 3 next
    do_reset();
    raise(4'b1100);
    begin_xfer(2, 1'b1, 1'b1, 1, 1'b0, '0, 1'b0, ok);
    raise(4'b0001);
    begin_xfer(3, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    if (ok) end_xfer(3, 0, W'($urandom));
    last_grant = 3;

    // Reset while ACTIVE
    raise(4'b0001);
    begin_xfer(0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    if (ok) end_xfer(0, 0, 32'h1234_5678);
    raise(4'b0010);
    begin_xfer(1, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    spi_end_req   = 1'b1;
    spi_cipo_data = 32'hDEAD_BEEF;
    #2 async_rst = 1'b1;
    #1;
    check("arst_req_ack", 128'(req_ack), 128'(0));
    check("arst_ctrl", 128'({spi_start_req, spi_end_ack, spi_cs_override}), 128'(0));
    check("arst_data", 128'(rsp_cipo_data), 128'(0));
    check("arst_cfg", 128'(spi_cfg), 128'(0));
    step();
    async_rst  = 1'b0;
    req_valid  = '0;
    pending    = '0;
    last_grant = N - 1;
    for (int n = 0; n < 3; n++) begin
      step();
      check("arst_no_rsp", 128'({rsp_valid, spi_end_ack}), 128'(0));
    end
    spi_end_req = 1'b0;
    raise(4'b0011);
    begin_xfer(0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    if (ok) end_xfer(0, 0, W'($urandom));
    last_grant = 0;

    // clk_en low in ACTIVE with spi_end_req pending
    raise(4'b0100);
    owner = rr_pick(pending, last_grant);
    begin_xfer(owner, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    step();
    clk_en        = 1'b0;
    spi_end_req   = 1'b1;
    spi_cipo_data = 32'hC0DE_0042;
    for (int n = 0; n < 10; n++) begin
      step();
      check("clk_en_hold", 128'({spi_end_ack, rsp_valid}), 128'(0));
    end
    clk_en = 1'b1;
    step();
    spi_end_req = 1'b0;
    check("clk_en_end_ack", 128'(spi_end_ack), 128'(1));
    check("clk_en_rsp", 128'(rsp_valid), 128'(oh(owner)));
    check("clk_en_cipo", 128'(rsp_cipo_data), 128'(32'hC0DE_0042));
    step();
    last_grant = owner;

    // Randomized stream against the round-robin model
    for (int t = 0; t < 60; t++) begin
      add = N'($urandom);
      if ((pending | add) == '0) add = oh($urandom_range(N - 1, 0));
      raise(add);
      owner = rr_pick(pending, last_grant);
      nak   = ($urandom_range(3, 0) == 0);
      begin_xfer(owner, nak, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
                 1'($urandom_range(1, 0)), N'($urandom), 1'b0, ok);
      if (ok) end_xfer(owner, $urandom_range(3, 0), W'($urandom));
      last_grant = owner;
    end

`ifdef SPI_ARB_LOCK_EN
    // Requester 1 keeps the bus for three transfers while 0 waits
    do_reset();
    raise(4'b0001);
    begin_xfer(0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    if (ok) end_xfer(0, 0, W'($urandom));
    req_lock = 4'b0010;
    raise(4'b0011);
    begin_xfer(1, 1'b0, 1'b0, 0, 1'b0, '0, 1'b1, ok);
    if (ok) end_xfer(1, 0, W'($urandom));
    raise(4'b0010);
    begin_xfer(1, 1'b0, 1'b0, 0, 1'b0, '0, 1'b1, ok);
    if (ok) end_xfer(1, 0, W'($urandom));
    req_lock = '0;
    raise(4'b0010);
    begin_xfer(1, 1'b0, 1'b0, 0, 1'b0, '0, 1'b1, ok);
    if (ok) end_xfer(1, 0, W'($urandom));
    check("lock_release", 128'(spi_cs_override), 128'(0));
    begin_xfer(0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ok);
    if (ok) end_xfer(0, 0, W'($urandom));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
